melody_player: RTL

- Parametrised successor to the single-song buzzer player.
- Plays one of NUM_SONGS melodies from an internal note ROM as a square wave on `beep`.
- Each ROM entry carries a pitch code and a duration in beats, so rests and variable note lengths are supported.
- Adds play/stop control, loop mode, a tempo multiplier, an articulation gap between notes, and status outputs; sits between the board button/switch logic and the buzzer pin.

---
 rtl/melody_player_if.sv | 26 ++
 rtl/melody_player.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_player_if.sv
// Control/status bundle between the button/switch logic and the melody player.
// The player owns the slave side and the board logic owns the master side.
interface melody_player_if #(
  parameter int SEL_W = 2,
  parameter int IDX_W = 6
);
  logic             play;
  logic             stop;
  logic [SEL_W-1:0] song_sel;
  logic             loop;
  logic [1:0]       tempo;
  logic             beep;
  logic             busy;
  logic [IDX_W-1:0] note_idx;
  logic             song_done;

  modport master (
    output play, stop, song_sel, loop, tempo,
    input  beep, busy, note_idx, song_done
  );

  modport slave (
    input  play, stop, song_sel, loop, tempo,
    output beep, busy, note_idx, song_done
  );
endinterface

// File: rtl/melody_player.sv
// Multi-song square-wave melody player: note ROM of {pitch, beats} entries,
// play/stop/loop control, tempo scaling and a silent articulation gap per note.
module melody_player #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BEAT_MS   = 250,
  parameter int GAP_MS    = 10,
  parameter int NUM_SONGS = 4,
  parameter int MAX_LEN   = 64
)(
  input  logic            clk,
  input  logic            rst,
  melody_player_if.slave  bus
);
  localparam int SEL_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BEAT_CYC = CLK_HZ / 1000 * BEAT_MS;
  localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
  // Longest note: 7 beats at half tempo (beat doubled).
  localparam int CNT_W    = $clog2(BEAT_CYC * 14 + GAP_CYC + 1);
  localparam int HALF_W   = $clog2(CLK_HZ / (2 * 392) + 1);

  localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_CYC);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYC);

  localparam logic [3:0] P_REST = 4'd0,  P_L5 = 4'd1,  P_L6 = 4'd2,  P_L7 = 4'd3;
  localparam logic [3:0] P_M1   = 4'd4,  P_M2 = 4'd5,  P_M3 = 4'd6,  P_M4 = 4'd7;
  localparam logic [3:0] P_M5   = 4'd8,  P_M6 = 4'd9,  P_M7 = 4'd10, P_H1 = 4'd11;
  localparam logic [3:0] P_END  = 4'd15;

  typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;

  function automatic logic [7:0] ent(input logic [3:0] p, input logic [2:0] b);
    return {p, b, 1'b0};
  endfunction

  // Last song slot is always the test pattern; slot 2 is left empty.
  function automatic logic [7:0] rom_rd(input logic [SEL_W-1:0] s, input logic [IDX_W-1:0] i);
    logic [7:0] e;
    e = ent(P_END, 3'd0);
    if (int'(s) == NUM_SONGS - 1) begin
      case (int'(i))
        0: e = ent(P_M1, 3'd1);
        1: e = ent(P_REST, 3'd1);
        2: e = ent(P_H1, 3'd2);
        default: e = ent(P_END, 3'd0);
      endcase
    end else if (int'(s) == 0) begin
      case (int'(i))
        0:  e = ent(P_M1, 3'd1);
        1:  e = ent(P_M1, 3'd1);
        2:  e = ent(P_M5, 3'd1);
        3:  e = ent(P_M5, 3'd1);
        4:  e = ent(P_M6, 3'd1);
        5:  e = ent(P_M6, 3'd1);
        6:  e = ent(P_M5, 3'd2);
        7:  e = ent(P_REST, 3'd1);
        8:  e = ent(P_M4, 3'd1);
        9:  e = ent(P_M4, 3'd1);
        10: e = ent(P_M3, 3'd1);
        11: e = ent(P_M3, 3'd1);
        12: e = ent(P_M2, 3'd1);
        13: e = ent(P_M2, 3'd1);
        14: e = ent(P_M1, 3'd2);
        default: e = ent(P_END, 3'd0);
      endcase
    end else if (int'(s) == 1) begin
      case (int'(i))
        0:  e = ent(P_L5, 3'd1);
        1:  e = ent(P_L6, 3'd1);
        2:  e = ent(P_L7, 3'd1);
        3:  e = ent(P_M1, 3'd1);
        4:  e = ent(P_M2, 3'd1);
        5:  e = ent(P_M3, 3'd1);
        6:  e = ent(P_M4, 3'd1);
        7:  e = ent(P_M5, 3'd1);
        8:  e = ent(P_M6, 3'd1);
        9:  e = ent(P_M7, 3'd1);
        10: e = ent(P_H1, 3'd3);
        default: e = ent(P_END, 3'd0);
      endcase
    end
    return e;
  endfunction

  function automatic logic [HALF_W-1:0] half_of(input logic [3:0] p);
    case (p)
      P_L5:    half_of = HALF_W'(CLK_HZ / (2 * 392));
      P_L6:    half_of = HALF_W'(CLK_HZ / (2 * 440));
      P_L7:    half_of = HALF_W'(CLK_HZ / (2 * 494));
      P_M1:    half_of = HALF_W'(CLK_HZ / (2 * 523));
      P_M2:    half_of = HALF_W'(CLK_HZ / (2 * 587));
      P_M3:    half_of = HALF_W'(CLK_HZ / (2 * 659));
      P_M4:    half_of = HALF_W'(CLK_HZ / (2 * 698));
      P_M5:    half_of = HALF_W'(CLK_HZ / (2 * 784));
      P_M6:    half_of = HALF_W'(CLK_HZ / (2 * 880));
      P_M7:    half_of = HALF_W'(CLK_HZ / (2 * 988));
      P_H1:    half_of = HALF_W'(CLK_HZ / (2 * 1047));
      default: half_of = '0;
    endcase
  endfunction

  state_t             state, state_n;
  logic [SEL_W-1:0]   song;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [HALF_W-1:0]  tone_cnt;
  logic               gap_on, beep_r, done_r;

  logic [7:0]         entry;
  logic [3:0]         pitch;
  logic [2:0]         beats, beats_eff;
  logic               spare_unused;
  logic [HALF_W-1:0]  half;
  logic               is_tone, is_end, gap_fit;
  logic [CNT_W-1:0]   beat_len, note_cyc, tone_len;

  assign entry        = rom_rd(song, idx);
  assign pitch        = entry[7:4];
  assign beats        = entry[3:1];
  assign spare_unused = entry[0];
  assign half         = half_of(pitch);
  assign is_tone      = (pitch != P_REST) && (pitch <= P_H1);
  // A song with no END marker is cut off at the last ROM slot.
  assign is_end       = (pitch == P_END) || (int'(idx) == MAX_LEN - 1);
  assign beats_eff    = (beats == 3'd0) ? 3'd1 : beats;

  always_comb begin
    beat_len = BEAT_C;
    case (bus.tempo)
      2'd1:    beat_len = BEAT_C >> 1;
      2'd2:    beat_len = BEAT_C >> 2;
      2'd3:    beat_len = BEAT_C << 1;
      default: beat_len = BEAT_C;
    endcase
  end

  assign note_cyc = beat_len * CNT_W'(beats_eff);
  assign gap_fit  = (GAP_C != '0) && (GAP_C < note_cyc);
  assign tone_len = gap_fit ? note_cyc - GAP_C : note_cyc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.play) state_n = LOAD;
      LOAD:    state_n = is_end ? (bus.loop ? LOAD : IDLE) : TONE;
      TONE:    if (cnt == '0) state_n = gap_on ? GAP : LOAD;
      GAP:     if (cnt == '0) state_n = LOAD;
      default: state_n = IDLE;
    endcase
    if (bus.stop) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      song     <= '0;
      idx      <= '0;
      cnt      <= '0;
      tone_cnt <= '0;
      gap_on   <= 1'b0;
      beep_r   <= 1'b0;
      done_r   <= 1'b0;
    end else if (bus.stop) begin
      idx      <= '0;
      cnt      <= '0;
      tone_cnt <= '0;
      beep_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.play) begin
          song <= bus.song_sel;
          idx  <= '0;
        end
        LOAD: if (is_end) begin
          done_r <= 1'b1;
          idx    <= '0;
        end else begin
          cnt      <= tone_len - 1'b1;
          gap_on   <= gap_fit;
          tone_cnt <= '0;
          beep_r   <= 1'b0;
        end
        TONE: if (cnt == '0) begin
          beep_r   <= 1'b0;
          tone_cnt <= '0;
          if (gap_on) cnt <= GAP_C - 1'b1;
          else        idx <= idx + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
          if (is_tone) begin
            if (tone_cnt == half - 1'b1) begin
              tone_cnt <= '0;
              beep_r   <= ~beep_r;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        GAP: if (cnt == '0) idx <= idx + 1'b1;
             else           cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.beep      = beep_r;
  assign bus.busy      = (state != IDLE);
  assign bus.note_idx  = idx;
  assign bus.song_done = done_r;
endmodule
